// File: rtl/dram_ctrl_if.sv
// Request/response handshake between the memory-side bus slave and dram_ctrl.
interface dram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [22:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dram_ctrl.sv
// Single-outstanding-request DRAM command sequencer (PRE/ACT/RD/WR on CSn/RASn/CASn/WEn/A).
// Define DRAM_OPEN_PAGE_EN for open-page policy; default build precharges after every access.
module dram_ctrl #(
  parameter int unsigned T_RP  = 5,
  parameter int unsigned T_RCD = 5,
  parameter int unsigned T_WR  = 5
) (
  input  logic        clk,
  input  logic        rst,
  dram_ctrl_if.slave  bus,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic        DRAM_valid
);

  localparam int unsigned ROW_W  = 11;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned WADR_W = ROW_W + COL_W;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned T_MAX0 = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int unsigned T_MAX  = (T_MAX0 > T_WR) ? T_MAX0 : T_WR;
  localparam int unsigned CNT_W  = $clog2(T_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRE    = 3'd1;
  localparam logic [2:0] S_ACT    = 3'd2;
  localparam logic [2:0] S_RD     = 3'd3;
  localparam logic [2:0] S_RDWAIT = 3'd4;
  localparam logic [2:0] S_WR     = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;

  // Policy: where a finished column access goes, and where a precharge leads.
`ifdef DRAM_OPEN_PAGE_EN
  localparam logic [2:0] S_AFTER_COL = S_RESP;
  localparam logic [2:0] S_AFTER_PRE = S_ACT;
`else
  localparam logic [2:0] S_AFTER_COL = S_PRE;
  localparam logic [2:0] S_AFTER_PRE = S_RESP;
`endif

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              row_open, row_open_nxt;
  logic [ROW_W-1:0]  open_row, open_row_nxt;
  logic              lat_write, lat_write_nxt;
  logic [WADR_W-1:0] lat_addr, lat_addr_nxt;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_nxt;
  logic [3:0]        lat_wstrb, lat_wstrb_nxt;
  logic              ready_reg, ready_nxt;
  logic              rsp_valid_reg, rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_nxt;
  logic              csn_nxt, rasn_nxt, casn_nxt;
  logic [3:0]        wen_nxt;
  logic [ROW_W-1:0]  a_nxt;
  logic [DATA_W-1:0] d_nxt;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^bus.req_addr[1:0];
  assign bus.req_ready   = ready_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_rdata   = rsp_rdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      row_open      <= 1'b0;
      open_row      <= '0;
      lat_write     <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_wstrb     <= '0;
      ready_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      DRAM_CSn      <= 1'b1;
      DRAM_RASn     <= 1'b1;
      DRAM_CASn     <= 1'b1;
      DRAM_WEn      <= 4'hF;
      DRAM_A        <= '0;
      DRAM_D        <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      row_open      <= row_open_nxt;
      open_row      <= open_row_nxt;
      lat_write     <= lat_write_nxt;
      lat_addr      <= lat_addr_nxt;
      lat_wdata     <= lat_wdata_nxt;
      lat_wstrb     <= lat_wstrb_nxt;
      ready_reg     <= ready_nxt;
      rsp_valid_reg <= rsp_valid_nxt;
      rsp_rdata_reg <= rsp_rdata_nxt;
      DRAM_CSn      <= csn_nxt;
      DRAM_RASn     <= rasn_nxt;
      DRAM_CASn     <= casn_nxt;
      DRAM_WEn      <= wen_nxt;
      DRAM_A        <= a_nxt;
      DRAM_D        <= d_nxt;
    end
  end

  // Next state, hold counter, and the pin image for the state being entered.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    row_open_nxt  = row_open;
    open_row_nxt  = open_row;
    lat_write_nxt = lat_write;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    lat_wstrb_nxt = lat_wstrb;
    rsp_rdata_nxt = rsp_rdata_reg;
    csn_nxt       = 1'b1;
    rasn_nxt      = 1'b1;
    casn_nxt      = 1'b1;
    wen_nxt       = 4'hF;
    a_nxt         = DRAM_A;
    d_nxt         = DRAM_D;

    case (state)
      S_IDLE: begin
        if (bus.req_valid && ready_reg) begin
          lat_write_nxt = bus.req_write;
          lat_addr_nxt  = bus.req_addr[22:2];
          lat_wdata_nxt = bus.req_wdata;
          lat_wstrb_nxt = bus.req_wstrb;
          if (row_open && (open_row == bus.req_addr[22:12]))
            state_nxt = bus.req_write ? S_WR : S_RD;
          else if (row_open)
            state_nxt = S_PRE;
          else
            state_nxt = S_ACT;
        end
      end
      S_PRE: begin
        if (cnt == '0) begin
          row_open_nxt = 1'b0;
          state_nxt    = S_AFTER_PRE;
        end
      end
      S_ACT: begin
        if (cnt == '0) begin
          row_open_nxt = 1'b1;
          open_row_nxt = lat_addr[WADR_W-1:COL_W];
          state_nxt    = lat_write ? S_WR : S_RD;
        end
      end
      S_RD:     state_nxt = S_RDWAIT;
      S_RDWAIT: begin
        if (DRAM_valid) begin
          rsp_rdata_nxt = DRAM_Q;
          state_nxt     = S_AFTER_COL;
        end
      end
      S_WR: begin
        if (cnt == '0)
          state_nxt = S_AFTER_COL;
      end
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    // Hold counter reloads on entry to a timed state, then counts down to zero.
    if (state_nxt != state) begin
      case (state_nxt)
        S_PRE:   cnt_nxt = CNT_W'(T_RP - 1);
        S_ACT:   cnt_nxt = CNT_W'(T_RCD - 1);
        S_WR:    cnt_nxt = CNT_W'(T_WR - 1);
        default: cnt_nxt = '0;
      endcase
    end else if (cnt != '0) begin
      cnt_nxt = cnt - CNT_W'(1);
    end

    ready_nxt     = (state_nxt == S_IDLE);
    rsp_valid_nxt = (state_nxt == S_RESP);

    case (state_nxt)
      S_PRE: begin
        csn_nxt  = 1'b0;
        rasn_nxt = 1'b0;
        wen_nxt  = 4'h0;
      end
      S_ACT: begin
        csn_nxt  = 1'b0;
        rasn_nxt = 1'b0;
        a_nxt    = lat_addr_nxt[WADR_W-1:COL_W];
      end
      S_RD: begin
        csn_nxt  = 1'b0;
        casn_nxt = 1'b0;
        a_nxt    = {1'b0, lat_addr_nxt[COL_W-1:0]};
      end
      S_WR: begin
        csn_nxt  = 1'b0;
        casn_nxt = 1'b0;
        wen_nxt  = ~lat_wstrb_nxt;
        a_nxt    = {1'b0, lat_addr_nxt[COL_W-1:0]};
        d_nxt    = lat_wdata_nxt;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dram_ctrl.md
# dram_ctrl

Sequencing controller between the SoC's memory-side bus slave and the external DRAM device. Accepts single-word read/write requests, translates each into DRAM row-precharge / row-activate / column commands on the CSn/RASn/CASn/WEn/A pins, and returns read data captured when the device asserts its valid strobe. Sits in `top` directly behind the DRAM AXI slave wrapper; drives the top-level DRAM_* pins.

## Interface
- T_RP, 5: cycles a PRECHARGE command is held before the next command.
- T_RCD, 5: cycles an ACTIVATE command is held before a column command.
- T_WR, 5: cycles a WRITE column command is held before completion.
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle (valid && ready).
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  23  byte address; row = [22:12], column = [11:2]; [1:0] ignored.
- req_wdata  input  32  write data.
- req_wstrb  input  4  byte enables, active-high.
- rsp_valid  output  1  one-cycle pulse: read data valid or write complete.
- rsp_rdata  output  32  read data, held until next rsp_valid.
- DRAM_CSn  output  1  chip select, active-low.
- DRAM_RASn  output  1  row strobe, active-low.
- DRAM_CASn  output  1  column strobe, active-low.
- DRAM_WEn  output  4  per-byte write enable, active-low.
- DRAM_A  output  11  row or column address.
- DRAM_D  output  32  write data.
- DRAM_Q  input  32  read data.
- DRAM_valid  input  1  read data valid strobe from device.

## Operation
- Commands (CSn=0): PRE = RASn 0, CASn 1, WEn 4'h0; ACT = RASn 0, CASn 1, WEn 4'hF, A = row; RD = RASn 1, CASn 0, WEn 4'hF, A = {1'b0, col}; WR = RASn 1, CASn 0, WEn = ~req_wstrb, A = {1'b0, col}, D = wdata. NOP = CSn 1, RASn 1, CASn 1, WEn 4'hF.
- States: IDLE, PRE, ACT, RD, RDWAIT, WR, RESP.
- IDLE: req_ready=1; on handshake latch write/addr/wdata/wstrb. Row open and row match -> RD/WR; row open and mismatch -> PRE; no row open -> ACT.
- PRE: drive PRE for T_RP cycles, clear row-open flag -> ACT.
- ACT: drive ACT for T_RCD cycles, record open row -> RD or WR.
- RD: drive RD one cycle -> RDWAIT (NOP on pins).
- RDWAIT: on DRAM_valid capture DRAM_Q into rsp_rdata -> RESP. DRAM_valid outside RDWAIT ignored.
- WR: drive WR for T_WR cycles -> RESP.
- RESP: rsp_valid=1 one cycle, NOP on pins -> IDLE.
- Hold counter: ceil(log2(max(T_RP,T_RCD,T_WR)+1)) bits, loads value-1 on state entry, exits at 0; any parameter value 1 gives a single-cycle command.
- One request outstanding; req_ready=0 in every state except IDLE.

## Timing
- Reset: IDLE, row-open flag 0, pins at NOP, DRAM_A 0, DRAM_D 0, req_ready 1 after release, rsp_valid 0, rsp_rdata 0.
- Read, row hit: handshake cycle N; RD on pins N+1; rsp_valid the cycle after DRAM_valid.
- Write, row hit: WR on pins N+1..N+T_WR; rsp_valid N+T_WR+1.
- Row miss adds T_RP+T_RCD cycles; closed bank adds T_RCD.
- All pin outputs registered; no combinational path from req_* to DRAM_*.
- rst mid-operation: pins return to NOP asynchronously, in-flight request dropped, no rsp_valid, row-open flag cleared.

## Configuration
- DRAM_OPEN_PAGE_EN defined: open-page policy as above; row stays open after RESP.
- Undefined: close-page; after RD-capture or WR completion the FSM enters PRE (T_RP) before RESP, row-open flag always 0 in IDLE, every access = ACT + column command + PRE.

## Test plan
- Reset: assert rst mid-cycle -> all DRAM pins NOP immediately, req_ready=1 and rsp_valid=0 after release.
- Write addr 0x000104, wdata 0xDEADBEEF, wstrb 4'b0011 -> ACT A=0x000 for 5 cycles, WR A=0x041 WEn=4'b1100 for 5 cycles, one rsp_valid pulse; model bytes 0/1 updated only.
- Read same address (open page), model returns DRAM_valid after 3 cycles with 0x1234BEEF -> no ACT/PRE issued, rsp_rdata=0x1234BEEF, rsp_valid one cycle after DRAM_valid.
- Read 0x001000 after row 0 open -> PRE 5 cycles, ACT A=0x001 5 cycles, RD A=0x000.
- Back-to-back req_valid held high -> req_ready low from handshake until IDLE; second request accepted the cycle after rsp_valid.
- DRAM_OPEN_PAGE_EN undefined: two reads to same row -> each shows ACT, RD, PRE sequence; rsp_valid only after PRE completes.
